ifm_pingpong_ctrl: RTL

Double-buffer (ping-pong) scheduler for the IFM memory between two convolution layer control units. It tracks which of two IFM banks the producing layer may write and which bank the consuming layer reads. It drives the start/end handshake between the layers, so the producer can fill one bank while the consumer convolves the other. It replaces the single-bank `start_to_next`/`end_from_next` stall with bank-level flow control.

---
 rtl/ifm_pingpong_if.sv | 44 ++++
 rtl/ifm_pingpong_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ifm_pingpong_if.sv
// Bank-level handshake bundle between the producing layer, the consuming layer
// and the IFM ping-pong controller.
interface ifm_pingpong_if #(
    parameter int FRAME_COUNT_WIDTH = 8
);
    logic                         prod_done;
    logic                         prod_ready;
    logic                         wr_bank_sel;
    logic                         cons_end;
    logic                         cons_start;
    logic                         rd_bank_sel;
    logic [1:0]                   occupancy;
    logic                         overflow_err;
    logic [FRAME_COUNT_WIDTH-1:0] frames_written;
    logic [FRAME_COUNT_WIDTH-1:0] frames_read;

    // Layer side: drives the done pulse and the consumer end level.
    modport master (
        output prod_done,
        output cons_end,
        input  prod_ready,
        input  wr_bank_sel,
        input  cons_start,
        input  rd_bank_sel,
        input  occupancy,
        input  overflow_err,
        input  frames_written,
        input  frames_read
    );

    // Controller side.
    modport slave (
        input  prod_done,
        input  cons_end,
        output prod_ready,
        output wr_bank_sel,
        output cons_start,
        output rd_bank_sel,
        output occupancy,
        output overflow_err,
        output frames_written,
        output frames_read
    );
endinterface

// File: rtl/ifm_pingpong_ctrl.sv
// Ping-pong IFM bank scheduler: the producer fills one bank while the consumer
// convolves the other, with start/end handshaking toward the consuming layer.
module ifm_pingpong_ctrl #(
    parameter int IFM_SIZE_NEXT     = 10,
    parameter int FRAME_COUNT_WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    ifm_pingpong_if.slave bus
);

    typedef enum logic [1:0] {
        B_EMPTY   = 2'b00,
        B_FULL    = 2'b01,
        B_READING = 2'b10
    } bank_state_e;

    typedef enum logic [1:0] {
        C_IDLE     = 2'b00,
        C_WAIT_LOW = 2'b01,
        C_BUSY     = 2'b10
    } cons_state_e;

    if (IFM_SIZE_NEXT < 1) begin : g_size_check
        $error("IFM_SIZE_NEXT must be at least 1");
    end

    bank_state_e                  bank_q [2];
    bank_state_e                  bank_d [2];
    cons_state_e                  state_q;
    logic                         wr_ptr_q, wr_ptr_d;
    logic                         rd_ptr_q, rd_ptr_d;
    logic [1:0]                   occ_q, occ_d;
    logic                         overflow_q, overflow_d;
    logic [FRAME_COUNT_WIDTH-1:0] fw_q, fw_d;
    logic [FRAME_COUNT_WIDTH-1:0] fr_q, fr_d;
    logic                         cons_start_q;

    logic prod_ready_s;
    logic accept_s;
    logic overflow_hit_s;
    logic launch_s;
    logic release_s;

    // Event decode from registered state and the two layer inputs.
    always_comb begin
        prod_ready_s   = (bank_q[wr_ptr_q] == B_EMPTY);
        accept_s       = bus.prod_done & prod_ready_s;
        overflow_hit_s = bus.prod_done & ~prod_ready_s;
        launch_s       = (state_q == C_IDLE) && (bank_q[rd_ptr_q] == B_FULL) && bus.cons_end;
        release_s      = (state_q == C_BUSY) && bus.cons_end;
    end

    // Next-state for banks, pointers, occupancy and statistics; a write and a
    // release in the same cycle always hit different banks, so both apply.
    always_comb begin
        bank_d[0]  = bank_q[0];
        bank_d[1]  = bank_q[1];
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fw_d       = fw_q;
        fr_d       = fr_q;
        overflow_d = overflow_q | overflow_hit_s;
        if (accept_s) begin
            bank_d[wr_ptr_q] = B_FULL;
            wr_ptr_d         = ~wr_ptr_q;
            fw_d             = fw_q + FRAME_COUNT_WIDTH'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (launch_s) begin
            bank_d[rd_ptr_q] = B_READING;
        end else if (release_s) begin
            bank_d[rd_ptr_q] = B_EMPTY;
            rd_ptr_d         = ~rd_ptr_q;
            fr_d             = fr_q + FRAME_COUNT_WIDTH'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({accept_s, release_s})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Consumer handshake FSM; cons_start is a one-cycle pulse on launch only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= C_IDLE;
            cons_start_q <= 1'b0;
        end else begin
            case (state_q)
                C_IDLE: begin
                    if (launch_s) begin
                        state_q      <= C_WAIT_LOW;
                        cons_start_q <= 1'b1;
                    end else begin
                        cons_start_q <= 1'b0;
                    end
                end
                C_WAIT_LOW: begin
                    cons_start_q <= 1'b0;
                    if (!bus.cons_end) begin
                        state_q <= C_BUSY;
                    end
                end
                C_BUSY: begin
                    cons_start_q <= 1'b0;
                    if (bus.cons_end) begin
                        state_q <= C_IDLE;
                    end
                end
                default: begin
                    state_q      <= C_IDLE;
                    cons_start_q <= 1'b0;
                end
            endcase
        end
    end

    // Bank, pointer and statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q[0]  <= B_EMPTY;
            bank_q[1]  <= B_EMPTY;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            overflow_q <= 1'b0;
            fw_q       <= '0;
            fr_q       <= '0;
        end else begin
            bank_q[0]  <= bank_d[0];
            bank_q[1]  <= bank_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
            fw_q       <= fw_d;
            fr_q       <= fr_d;
        end
    end

    assign bus.prod_ready     = prod_ready_s;
    assign bus.wr_bank_sel    = wr_ptr_q;
    assign bus.rd_bank_sel    = rd_ptr_q;
    assign bus.cons_start     = cons_start_q;
    assign bus.occupancy      = occ_q;
    assign bus.overflow_err   = overflow_q;
    assign bus.frames_written = fw_q;
    assign bus.frames_read    = fr_q;

endmodule
